// File: rtl/julia_pkg.sv
// Shared types and constants for the Julia-set frame scheduler: Q16.16 fixed point,
// operator command encodings and the scheduler FSM states.
package julia_pkg;

  localparam int FRAC = 16;
  // Thousandths to Q16.16: round(2^FRAC / 1000) = 66.
  localparam int K_MILLI = ((1 << FRAC) + 500) / 1000;

  typedef logic signed [31:0] fix_t;

  typedef enum logic [1:0] {
    LOAD_RE = 2'b00,
    LOAD_IM = 2'b01,
    CFG_NOP = 2'b10,
    START   = 2'b11
  } cfg_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_DRAIN,
    S_DONE
  } sched_e;

  // Signed thousandths in the low half-word to Q16.16, keeping the low 32 bits.
  function automatic fix_t milli_to_fix(input logic [15:0] milli);
    fix_t wide;
    wide = fix_t'($signed(milli));
    return fix_t'(wide * fix_t'(K_MILLI));
  endfunction

endpackage

// File: rtl/julia_result_wb.sv
// Result write-back stage: one-entry output register toward the frame buffer,
// intensity clamp and raster address computation.
module julia_result_wb
  import julia_pkg::*;
#(
  parameter int IMG_W    = 640,
  parameter int MAX_ITER = 100
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        accept_en_i,
  input  logic        res_valid_i,
  input  logic [9:0]  res_x_i,
  input  logic [8:0]  res_y_i,
  input  logic [7:0]  res_iter_i,
  input  logic        res_esc_i,
  input  logic        wr_ready_i,
  output logic        res_ready_o,
  output logic        res_take_o,
  output logic        wr_valid_o,
  output logic [18:0] wr_addr_o,
  output logic [7:0]  wr_data_o
);

  logic        wr_valid_q, wr_valid_d;
  logic [18:0] wr_addr_q, wr_addr_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        slot_free;

  assign slot_free   = !wr_valid_q || wr_ready_i;
  // Outside a frame results are swallowed so a stale engine can always drain.
  assign res_ready_o = accept_en_i ? slot_free : 1'b1;
  assign res_take_o  = accept_en_i && res_valid_i && slot_free;

  // NOTE: every always_comb output gets a default first so no path infers a latch.
  always_comb begin
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    wr_valid_d = wr_valid_q && !wr_ready_i;
    if (res_take_o) begin
      wr_valid_d = 1'b1;
      wr_addr_d  = 19'(res_y_i) * 19'(IMG_W) + 19'(res_x_i);
      if (!res_esc_i)
        wr_data_d = '0;
      else if (res_iter_i > 8'(MAX_ITER))
        wr_data_d = 8'(MAX_ITER);
      else
        wr_data_d = res_iter_i;
    end
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      wr_valid_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      wr_valid_q <= wr_valid_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign wr_valid_o = wr_valid_q;
  assign wr_addr_o  = wr_addr_q;
  assign wr_data_o  = wr_data_q;

endmodule

// File: rtl/julia_frame_sched.sv
// Frame scheduler: latches c, raster-scans the frame issuing z0 to the iteration
// engine, tracks pixels in flight and hands results to the write-back stage.
module julia_frame_sched
  import julia_pkg::*;
#(
  parameter int   IMG_W    = 640,
  parameter int   IMG_H    = 480,
  parameter int   MAX_ITER = 100,
  parameter fix_t STEP     = 32'sd410,
  parameter int   MAX_OUT  = 8
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] coord_in,
  input  logic [1:0]  state,
  output logic [31:0] c_re,
  output logic [31:0] c_im,
  output logic        px_valid,
  input  logic        px_ready,
  output logic [9:0]  px_x,
  output logic [8:0]  px_y,
  output logic [31:0] z0_re,
  output logic [31:0] z0_im,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [9:0]  res_x,
  input  logic [8:0]  res_y,
  input  logic [7:0]  res_iter,
  input  logic        res_esc,
  output logic        wr_valid,
  input  logic        wr_ready,
  output logic [18:0] wr_addr,
  output logic [7:0]  wr_data,
  output logic        busy,
  output logic        done
);

  localparam int   OUT_W  = $clog2(MAX_OUT + 1);
  localparam fix_t Z0_RE0 = fix_t'(-(IMG_W / 2)) * STEP;
  localparam fix_t Z0_IM0 = fix_t'(-(IMG_H / 2)) * STEP;

  sched_e           state_q, state_d;
  cfg_op_e          op;
  logic             start_lvl_q, start_ok, idle_like, issue_hs, res_take, last_px;
  logic [9:0]       px_x_q, px_x_d;
  logic [8:0]       px_y_q, px_y_d;
  fix_t             z0_re_q, z0_re_d, z0_im_q, z0_im_d;
  fix_t             c_re_q, c_re_d, c_im_q, c_im_d;
  logic [OUT_W-1:0] out_q, out_d;
  logic             coord_unused;

  assign coord_unused = ^coord_in[31:16];

  assign op        = cfg_op_e'(state);
  assign idle_like = (state_q == S_IDLE) || (state_q == S_DONE);
  // Only a 0->1 transition of the start command counts; holding it does nothing.
  assign start_ok  = (op == START) && !start_lvl_q && idle_like;
  assign busy      = (state_q == S_ISSUE) || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign px_valid  = (state_q == S_ISSUE) && (out_q < OUT_W'(MAX_OUT));
  assign issue_hs  = px_valid && px_ready;
  assign last_px   = (px_x_q == 10'(IMG_W - 1)) && (px_y_q == 9'(IMG_H - 1));

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE, S_DONE: if (start_ok) state_d = S_ISSUE;
      S_ISSUE:        if (issue_hs && last_px) state_d = S_DRAIN;
      S_DRAIN:        if (out_q == '0 && !wr_valid) state_d = S_DONE;
      default:        state_d = S_IDLE;
    endcase
  end

  // Raster scan by incremental adds: the start point is reloaded at each line wrap.
  always_comb begin
    px_x_d  = px_x_q;
    px_y_d  = px_y_q;
    z0_re_d = z0_re_q;
    z0_im_d = z0_im_q;
    if (start_ok) begin
      px_x_d  = '0;
      px_y_d  = '0;
      z0_re_d = Z0_RE0;
      z0_im_d = Z0_IM0;
    end else if (issue_hs) begin
      if (px_x_q == 10'(IMG_W - 1)) begin
        px_x_d  = '0;
        z0_re_d = Z0_RE0;
        px_y_d  = px_y_q + 9'd1;
        z0_im_d = z0_im_q + STEP;
      end else begin
        px_x_d  = px_x_q + 10'd1;
        z0_re_d = z0_re_q + STEP;
      end
    end
  end

  always_comb begin
    out_d = out_q;
    if (start_ok)
      out_d = '0;
    else if (issue_hs && !res_take)
      out_d = out_q + OUT_W'(1);
    else if (!issue_hs && res_take)
      out_d = out_q - OUT_W'(1);
  end

  always_comb begin
    c_re_d = c_re_q;
    c_im_d = c_im_q;
    if (idle_like && op == LOAD_RE) c_re_d = milli_to_fix(coord_in[15:0]);
    if (idle_like && op == LOAD_IM) c_im_d = milli_to_fix(coord_in[15:0]);
  end

  // NOTE: every control and datapath register is reset so a mid-frame RESET leaves no stale state.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q     <= S_IDLE;
      start_lvl_q <= 1'b0;
      px_x_q      <= '0;
      px_y_q      <= '0;
      z0_re_q     <= '0;
      z0_im_q     <= '0;
      c_re_q      <= '0;
      c_im_q      <= '0;
      out_q       <= '0;
    end else begin
      state_q     <= state_d;
      start_lvl_q <= (op == START);
      px_x_q      <= px_x_d;
      px_y_q      <= px_y_d;
      z0_re_q     <= z0_re_d;
      z0_im_q     <= z0_im_d;
      c_re_q      <= c_re_d;
      c_im_q      <= c_im_d;
      out_q       <= out_d;
    end
  end

  julia_result_wb #(
    .IMG_W    (IMG_W),
    .MAX_ITER (MAX_ITER)
  ) u_wb (
    .CLK         (CLK),
    .RESET       (RESET),
    .accept_en_i (busy),
    .res_valid_i (res_valid),
    .res_x_i     (res_x),
    .res_y_i     (res_y),
    .res_iter_i  (res_iter),
    .res_esc_i   (res_esc),
    .wr_ready_i  (wr_ready),
    .res_ready_o (res_ready),
    .res_take_o  (res_take),
    .wr_valid_o  (wr_valid),
    .wr_addr_o   (wr_addr),
    .wr_data_o   (wr_data)
  );

  assign c_re  = c_re_q;
  assign c_im  = c_im_q;
  assign px_x  = px_x_q;
  assign px_y  = px_y_q;
  assign z0_re = z0_re_q;
  assign z0_im = z0_im_q;

endmodule

// File: tb/tb_julia_frame_sched.sv
// Directed-plus-random bench for julia_frame_sched on a 4x2 frame with a unit step,
// checked against a pixel-list / write-queue reference model.
module tb_julia_frame_sched;

  localparam int W      = 4;
  localparam int H      = 2;
  localparam int NPIX   = W * H;
  localparam int MAXIT  = 100;
  localparam int MAXOUT = 8;
  localparam int STEPV  = 65536;
  localparam int LIMIT  = 2000;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] coord_in;
  logic [1:0]  state;
  logic [31:0] c_re, c_im, z0_re, z0_im;
  logic        px_valid, px_ready;
  logic [9:0]  px_x;
  logic [8:0]  px_y;
  logic        res_valid, res_ready, res_esc;
  logic [9:0]  res_x;
  logic [8:0]  res_y;
  logic [7:0]  res_iter;
  logic        wr_valid, wr_ready;
  logic [18:0] wr_addr;
  logic [7:0]  wr_data;
  logic        busy, done;

  julia_frame_sched #(
    .IMG_W(W), .IMG_H(H), .MAX_ITER(MAXIT), .STEP(32'sd65536), .MAX_OUT(MAXOUT)
  ) dut (
    .CLK(CLK), .RESET(RESET), .coord_in(coord_in), .state(state),
    .c_re(c_re), .c_im(c_im),
    .px_valid(px_valid), .px_ready(px_ready), .px_x(px_x), .px_y(px_y),
    .z0_re(z0_re), .z0_im(z0_im),
    .res_valid(res_valid), .res_ready(res_ready), .res_x(res_x), .res_y(res_y),
    .res_iter(res_iter), .res_esc(res_esc),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int         x;
    int         y;
    logic [7:0] iter;
    logic       esc;
    int         t;
  } pix_t;

  typedef struct {
    int addr;
    int data;
  } wr_t;

  int   vectors = 0;
  int   miscompares = 0;
  pix_t infl[$];
  wr_t  wq[$];
  pix_t cur;
  int   cyc, issued, accepted, written;
  bit   released;
  logic [31:0] c_re_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d (0x%08h) expected %0d (0x%08h)",
             tag, $signed(obs), obs, $signed(exp), exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic int clamp_ref(input int iter, input bit esc);
    if (!esc) return 0;
    return (iter > MAXIT) ? MAXIT : iter;
  endfunction

  function automatic int fix_ref(input logic [31:0] c);
    logic signed [15:0] m;
    m = c[15:0];
    return int'(m) * 66;
  endfunction

  function automatic int z0re_ref(input int k);
    return -(W / 2) * STEPV + (k % W) * STEPV;
  endfunction

  function automatic int z0im_ref(input int k);
    return -(H / 2) * STEPV + (k / W) * STEPV;
  endfunction

  task automatic check_zero(input string tag);
    check({tag, "_c_re"}, c_re, 32'(0));
    check({tag, "_c_im"}, c_im, 32'(0));
    check({tag, "_px_valid"}, 32'(px_valid), 32'(0));
    check({tag, "_px_x"}, 32'(px_x), 32'(0));
    check({tag, "_px_y"}, 32'(px_y), 32'(0));
    check({tag, "_z0_re"}, z0_re, 32'(0));
    check({tag, "_z0_im"}, z0_im, 32'(0));
    check({tag, "_wr_valid"}, 32'(wr_valid), 32'(0));
    check({tag, "_wr_addr"}, 32'(wr_addr), 32'(0));
    check({tag, "_wr_data"}, 32'(wr_data), 32'(0));
    check({tag, "_busy"}, 32'(busy), 32'(0));
    check({tag, "_done"}, 32'(done), 32'(0));
    check({tag, "_res_ready"}, 32'(res_ready), 32'(1));
  endtask

  // Start pulse from a drive point; the first pixel must be on offer one cycle later.
  task automatic start_frame(input bit hold);
    state     = 2'b11;
    res_valid = 1'b0;
    px_ready  = 1'b0;
    wr_ready  = 1'b1;
    tick();
    if (!hold) state = 2'b10;
    check("start_busy", 32'(busy), 32'(1));
    check("start_done", 32'(done), 32'(0));
    check("start_px_valid", 32'(px_valid), 32'(1));
    check("start_px_x", 32'(px_x), 32'(0));
    check("start_px_y", 32'(px_y), 32'(0));
    check("start_z0_re", z0_re, 32'(z0re_ref(0)));
    check("start_z0_im", z0_im, 32'(z0im_ref(0)));
  endtask

  // px_mode/wr_mode: 0 always ready, 1 random, 2 (wr only) stalled for 20 cycles.
  // eng_mode: 0 in order, 1 out of order, 2 hold until MAX_OUT in flight then out of order.
  // data_mode: 0 iter=x+y escaped, 1 clamp corner cases then random.
  // mid_mode: 1 config load while busy, 2 start edge while busy.
  task automatic run_frame(input int px_mode, input int wr_mode, input int eng_mode,
                           input int data_mode, input int stop_issue, input int mid_mode,
                           input bit hold);
    bit   res_acc;
    int   idx;
    pix_t p;
    wr_t  e;
    cyc = 0; issued = 0; accepted = 0; written = 0; released = 1'b0;
    infl.delete();
    wq.delete();
    res_valid = 1'b0;
    while (written < NPIX && cyc < LIMIT && !(stop_issue > 0 && issued >= stop_issue)) begin
      px_ready = (px_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      if (wr_mode == 0)      wr_ready = 1'b1;
      else if (wr_mode == 1) wr_ready = ($urandom_range(0, 3) != 0);
      else                   wr_ready = (cyc >= 20);
      coord_in = 32'd999;
      if (hold)                                  state = 2'b11;
      else if (mid_mode == 1 && cyc inside {[2:4]}) state = 2'b00;
      else if (mid_mode == 2 && cyc == 6)        state = 2'b11;
      else                                       state = 2'b10;
      if (!res_valid && infl.size() > 0) begin
        if (eng_mode == 2 && !released &&
            (issued - accepted >= MAXOUT || issued == NPIX)) released = 1'b1;
        if (eng_mode != 2 || released) begin
          idx = (eng_mode == 0) ? 0 : int'($urandom_range(0, infl.size() - 1));
          if (infl[idx].t < cyc && (eng_mode == 0 || $urandom_range(0, 3) != 0)) begin
            cur = infl[idx];
            infl.delete(idx);
            res_valid = 1'b1;
            res_x     = 10'(cur.x);
            res_y     = 9'(cur.y);
            res_iter  = cur.iter;
            res_esc   = cur.esc;
          end
        end
      end
      #1;
      res_acc = 1'b0;
      check("busy_in_frame", 32'(busy), 32'(1));
      check("px_valid", 32'(px_valid), 32'(issued < NPIX && (issued - accepted) < MAXOUT));
      if (px_valid && px_ready) begin
        check($sformatf("px_x[%0d]", issued), 32'(px_x), 32'(issued % W));
        check($sformatf("px_y[%0d]", issued), 32'(px_y), 32'(issued / W));
        check($sformatf("z0_re[%0d]", issued), z0_re, 32'(z0re_ref(issued)));
        check($sformatf("z0_im[%0d]", issued), z0_im, 32'(z0im_ref(issued)));
        p.x = issued % W;
        p.y = issued / W;
        p.t = cyc;
        if (data_mode == 0)   begin p.iter = 8'(p.x + p.y); p.esc = 1'b1; end
        else if (issued == 0) begin p.iter = 8'd200; p.esc = 1'b1; end
        else if (issued == 1) begin p.iter = 8'd37;  p.esc = 1'b0; end
        else begin p.iter = 8'($urandom); p.esc = 1'($urandom_range(0, 1)); end
        infl.push_back(p);
        issued++;
      end
      if (res_valid && res_ready) begin
        e.addr = cur.y * W + cur.x;
        e.data = clamp_ref(int'(cur.iter), cur.esc);
        wq.push_back(e);
        accepted++;
        res_acc = 1'b1;
      end
      if (wr_valid && wr_ready) begin
        if (wq.size() == 0) check("wr_expected_pending", 32'(wq.size()), 32'(1));
        else begin
          e = wq.pop_front();
          check($sformatf("wr_addr[%0d]", written), 32'(wr_addr), 32'(e.addr));
          check($sformatf("wr_data[%0d]", written), 32'(wr_data), 32'(e.data));
        end
        written++;
      end
      tick();
      if (res_acc) res_valid = 1'b0;
      cyc++;
    end
    if (cyc >= LIMIT) check("frame_timeout_writes", 32'(written), 32'(NPIX));
    if (stop_issue == 0 && cyc < LIMIT) begin
      check("end_done_pre", 32'(done), 32'(0));
      check("end_busy_pre", 32'(busy), 32'(1));
      tick();
      check("end_done", 32'(done), 32'(1));
      check("end_busy", 32'(busy), 32'(0));
      check("end_px_valid", 32'(px_valid), 32'(0));
      check("end_wr_valid", 32'(wr_valid), 32'(0));
      check("end_leftover", 32'(wq.size() + infl.size()), 32'(0));
    end
  endtask

  initial begin
    logic [31:0] v;
    RESET = 1'b1; state = 2'b10; coord_in = '0; px_ready = 1'b0; wr_ready = 1'b0;
    res_valid = 1'b0; res_x = '0; res_y = '0; res_iter = '0; res_esc = 1'b0;
    repeat (3) tick();
    check_zero("reset");
    RESET = 1'b0;

    state = 2'b00; coord_in = 32'd156;       tick();
    state = 2'b01; coord_in = 32'hFFFF_FDE1; tick();
    state = 2'b10;
    check("cfg_c_re", c_re, 32'(10296));
    check("cfg_c_im", c_im, 32'(-35838));
    for (int i = 0; i < 4; i++) begin
      v = $urandom;
      state = 2'(i % 2); coord_in = v; tick();
      check($sformatf("cfg_rand[%0d]", i), (i % 2 == 0) ? c_re : c_im, 32'(fix_ref(v)));
    end
    state = 2'b00; coord_in = 32'd156; tick();
    state = 2'b10; tick();
    c_re_exp = 32'(fix_ref(32'd156));

    start_frame(1'b0);
    run_frame(0, 0, 0, 0, 0, 1, 1'b0);
    check("busy_load_c_re", c_re, c_re_exp);

    start_frame(1'b0);
    run_frame(1, 2, 2, 0, 0, 2, 1'b0);

    start_frame(1'b0);
    run_frame(1, 1, 0, 1, 0, 0, 1'b0);

    start_frame(1'b0);
    run_frame(1, 1, 1, 1, 3, 0, 1'b0);
    RESET = 1'b1; res_valid = 1'b0; state = 2'b10; px_ready = 1'b0;
    tick();
    check_zero("mid_reset");
    RESET = 1'b0;
    res_valid = 1'b1; res_x = 10'd1; res_y = 9'd0; res_iter = 8'd5; res_esc = 1'b1;
    #1;
    check("late_res_ready", 32'(res_ready), 32'(1));
    tick();
    res_valid = 1'b0;
    check("late_wr_valid", 32'(wr_valid), 32'(0));
    check("late_busy", 32'(busy), 32'(0));
    tick();

    start_frame(1'b0);
    run_frame(1, 1, 1, 1, 0, 0, 1'b0);

    start_frame(1'b1);
    run_frame(0, 0, 1, 0, 0, 0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("hold_done[%0d]", i), 32'(done), 32'(1));
      check($sformatf("hold_busy[%0d]", i), 32'(busy), 32'(0));
      check($sformatf("hold_px_valid[%0d]", i), 32'(px_valid), 32'(0));
    end
    state = 2'b10;
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
